// File: rtl/vreg_bank.sv
// vreg_bank: flat scalar/vector register file with per-lane write mask and busy scoreboard.
// Latency: reads/busy combinational, writes/busy updates/rsv_err take effect after one clk edge.
// Backpressure: none; decode stalls on busy1/busy2. Optional same-cycle write bypass: REGFILE_BYPASS_EN.
module vreg_bank #(
  parameter int NS  = 12,
  parameter int NV  = 4,
  parameter int L   = 4,
  parameter int W   = 32,
  parameter int TAP = 11,
  localparam int A  = $clog2(NS + NV)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           we,
  input  logic [A-1:0]   wa,
  input  logic [L-1:0]   wmask,
  input  logic [L*W-1:0] wd,
  input  logic [A-1:0]   ra1,
  input  logic [A-1:0]   ra2,
  output logic [L*W-1:0] rd1,
  output logic [L*W-1:0] rd2,
  input  logic           rsv,
  input  logic [A-1:0]   rsv_a,
  output logic           busy1,
  output logic           busy2,
  output logic           rsv_err,
  output logic [W-1:0]   tap
);

  localparam int N  = NS + NV;
  localparam int SA = (NS > 1) ? $clog2(NS) : 1;
  localparam int VA = (NV > 1) ? $clog2(NV) : 1;
  localparam logic [A:0] NS_X = (A+1)'(NS);
  localparam logic [A:0] N_X  = (A+1)'(N);

  logic [W-1:0]   rf_q [NS];
  logic [W-1:0]   rf_d [NS];
  logic [L*W-1:0] rv_q [NV];
  logic [L*W-1:0] rv_d [NV];
  logic [N-1:0]   busy_q, busy_d;
  logic           rsv_err_q, rsv_err_d;

  function automatic logic is_scl(input logic [A-1:0] a);
    return {1'b0, a} < NS_X;
  endfunction

  function automatic logic is_map(input logic [A-1:0] a);
    return {1'b0, a} < N_X;
  endfunction

  function automatic logic [SA-1:0] sidx(input logic [A-1:0] a);
    return SA'(a);
  endfunction

  function automatic logic [VA-1:0] vidx(input logic [A-1:0] a);
    logic [A-1:0] d;
    d = a - NS_X[A-1:0];
    return VA'(d);
  endfunction

  // True when the port address is being written this cycle and bypass is compiled in.
  function automatic logic byp_hit(input logic [A-1:0] a);
`ifdef REGFILE_BYPASS_EN
    return we && (wa == a) && is_map(a);
`else
    return 1'b0;
`endif
  endfunction

  // Read mux: scalars zero-extended into lane 0, unmapped addresses read as zero.
  function automatic logic [L*W-1:0] rd_port(input logic [A-1:0] a);
    logic [L*W-1:0] v;
    v = '0;
    if (is_scl(a)) begin
      v[W-1:0] = byp_hit(a) ? wd[W-1:0] : rf_q[sidx(a)];
    end else if (is_map(a)) begin
      v = rv_q[vidx(a)];
      if (byp_hit(a)) begin
        for (int i = 0; i < L; i++) begin
          if (wmask[i]) v[i*W +: W] = wd[i*W +: W];
        end
      end
    end
    return v;
  endfunction

  function automatic logic busy_port(input logic [A-1:0] a);
    return is_map(a) && busy_q[a] && !byp_hit(a);
  endfunction

  // Read ports, scoreboard lookups and the scalar tap.
  always_comb begin
    rd1     = rd_port(ra1);
    rd2     = rd_port(ra2);
    busy1   = busy_port(ra1);
    busy2   = busy_port(ra2);
    rsv_err = rsv_err_q;
    tap     = rf_q[TAP];
  end

  // Next state: masked write, write clears busy, reservation sets it last so it wins.
  always_comb begin
    rf_d      = rf_q;
    rv_d      = rv_q;
    busy_d    = busy_q;
    rsv_err_d = 1'b0;
    if (we && is_map(wa)) begin
      if (is_scl(wa)) begin
        rf_d[sidx(wa)] = wd[W-1:0];
      end else begin
        for (int i = 0; i < L; i++) begin
          if (wmask[i]) rv_d[vidx(wa)][i*W +: W] = wd[i*W +: W];
        end
      end
      busy_d[wa] = 1'b0;
    end
    if (rsv && is_map(rsv_a)) begin
      if (busy_q[rsv_a] && !(we && wa == rsv_a)) rsv_err_d = 1'b1;
      busy_d[rsv_a] = 1'b1;
    end
  end

  // State registers; synchronous reset clears data, scoreboard and error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) rf_q[i] <= '0;
      for (int i = 0; i < NV; i++) rv_q[i] <= '0;
      busy_q    <= '0;
      rsv_err_q <= 1'b0;
    end else begin
      rf_q      <= rf_d;
      rv_q      <= rv_d;
      busy_q    <= busy_d;
      rsv_err_q <= rsv_err_d;
    end
  end

endmodule

// File: tb/tb_vreg_bank.sv
// Directed table-driven bench for vreg_bank (default parameters: 12 scalar, 4 vector, 4x32).
// Inputs driven on the falling edge, outputs compared 1ns later, state advances on the rising edge.
// Expected values are hand-computed constants; bypass-dependent ones follow REGFILE_BYPASS_EN.
module tb_vreg_bank;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, we, rsv;
  logic [3:0]   wa, ra1, ra2, rsv_a, wmask;
  logic [127:0] wd, rd1, rd2;
  logic         busy1, busy2, rsv_err;
  logic [31:0]  tap;

  int n_tests = 0;
  int n_fail  = 0;

  vreg_bank dut (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wmask(wmask), .wd(wd),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .rsv(rsv), .rsv_a(rsv_a),
    .busy1(busy1), .busy2(busy2), .rsv_err(rsv_err), .tap(tap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         we;
    logic [3:0]   wa;
    logic [3:0]   wmask;
    logic [127:0] wd;
    logic [3:0]   ra1;
    logic [3:0]   ra2;
    logic         rsv;
    logic [3:0]   rsv_a;
    logic [127:0] e_rd1;
    logic [127:0] e_rd2;
    logic         e_b1;
    logic         e_b2;
    logic         e_err;
    logic [31:0]  e_tap;
  } vec_t;

  localparam logic [127:0] WD11  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_DEAD_BEEF;
  localparam logic [127:0] S11   = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
  localparam logic [127:0] VINIT = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
  localparam logic [127:0] AA    = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA;
  localparam logic [127:0] V13M  = 128'h4444_4444_AAAA_AAAA_2222_2222_AAAA_AAAA;
  localparam logic [127:0] F5    = 128'h0000_0005_0000_0005_0000_0005_0000_0005;
  localparam logic [127:0] F7    = 128'h0000_0007_0000_0007_0000_0007_0000_0007;
  localparam logic [127:0] F77   = 128'h0000_0077_0000_0077_0000_0077_0000_0077;
  localparam logic [31:0]  DB    = 32'hDEAD_BEEF;

  vec_t tbl [14];

  function automatic vec_t mk(
    input logic we_, input logic [3:0] wa_, input logic [3:0] m_, input logic [127:0] wd_,
    input logic [3:0] r1_, input logic [3:0] r2_, input logic rsv_, input logic [3:0] ra_,
    input logic [127:0] x1_, input logic [127:0] x2_, input logic b1_, input logic b2_,
    input logic err_, input logic [31:0] tap_);
    vec_t v;
    v.we = we_; v.wa = wa_; v.wmask = m_; v.wd = wd_; v.ra1 = r1_; v.ra2 = r2_;
    v.rsv = rsv_; v.rsv_a = ra_; v.e_rd1 = x1_; v.e_rd2 = x2_; v.e_b1 = b1_;
    v.e_b2 = b2_; v.e_err = err_; v.e_tap = tap_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [3:0] m,
                       input logic [127:0] d, input logic [3:0] p1, input logic [3:0] p2,
                       input logic s, input logic [3:0] sa);
    rst = r; we = w; wa = a; wmask = m; wd = d; ra1 = p1; ra2 = p2; rsv = s; rsv_a = sa;
  endtask

  initial begin
    //            we wa  mask  wd     ra1 ra2 rsv rsva | rd1   rd2   b1 b2 err tap
    tbl[0]  = mk(1, 11, 4'h0, WD11,  0, 13, 0, 0,    '0,   '0,   0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 13, 4'hF, VINIT, 11, 12, 0, 0,   S11,  '0,   0, 0, 0, DB);
    tbl[2]  = mk(0, 0,  4'h0, '0,    13, 11, 0, 0,   VINIT, S11, 0, 0, 0, DB);
    tbl[3]  = mk(1, 13, 4'h5, AA,    0, 11, 0, 0,    '0,   S11,  0, 0, 0, DB);
    tbl[4]  = mk(0, 0,  4'h0, '0,    13, 14, 1, 14,  V13M, '0,   0, 0, 0, DB);
    tbl[5]  = mk(0, 0,  4'h0, '0,    14, 13, 1, 14,  '0,   V13M, 1, 0, 0, DB);
    tbl[6]  = mk(1, 14, 4'hF, F5,    0, 13, 0, 0,    '0,   V13M, 0, 0, 1, DB);
    tbl[7]  = mk(0, 0,  4'h0, '0,    14, 11, 0, 0,   F5,   S11,  0, 0, 0, DB);
    tbl[8]  = mk(1, 14, 4'hF, F7,    13, 11, 1, 14,  V13M, S11,  0, 0, 0, DB);
    tbl[9]  = mk(0, 0,  4'h0, '0,    14, 0,  0, 0,   F7,   '0,   1, 0, 0, DB);
    tbl[10] = mk(1, 14, 4'h0, '0,    13, 12, 1, 14,  V13M, '0,   0, 0, 0, DB);
    tbl[11] = mk(0, 0,  4'h0, '0,    14, 15, 0, 0,   F7,   '0,   1, 0, 0, DB);
    tbl[12] = mk(1, 14, 4'h0, '0,    13, 0,  0, 0,   V13M, '0,   0, 0, 0, DB);
    tbl[13] = mk(0, 0,  4'h0, '0,    14, 0,  0, 0,   F7,   '0,   0, 0, 0, DB);

    drive(1, 0, 0, 0, '0, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state across the whole address space.
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      drive(0, 0, 0, 0, '0, 4'(a), 4'(15 - a), 0, 0);
      #1;
      chk($sformatf("reset rd1[%0d]", a), rd1, '0);
      chk($sformatf("reset rd2[%0d]", 15 - a), rd2, '0);
      chk($sformatf("reset busy1[%0d]", a), {127'b0, busy1}, '0);
      chk($sformatf("reset busy2[%0d]", 15 - a), {127'b0, busy2}, '0);
    end
    chk("reset tap", {96'b0, tap}, '0);
    chk("reset rsv_err", {127'b0, rsv_err}, '0);

    // Table: writes, masks, reservations, error pulse, busy clearing.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(0, tbl[i].we, tbl[i].wa, tbl[i].wmask, tbl[i].wd, tbl[i].ra1, tbl[i].ra2,
            tbl[i].rsv, tbl[i].rsv_a);
      #1;
      chk($sformatf("row%0d rd1", i), rd1, tbl[i].e_rd1);
      chk($sformatf("row%0d rd2", i), rd2, tbl[i].e_rd2);
      chk($sformatf("row%0d busy1", i), {127'b0, busy1}, {127'b0, tbl[i].e_b1});
      chk($sformatf("row%0d busy2", i), {127'b0, busy2}, {127'b0, tbl[i].e_b2});
      chk($sformatf("row%0d rsv_err", i), {127'b0, rsv_err}, {127'b0, tbl[i].e_err});
      chk($sformatf("row%0d tap", i), {96'b0, tap}, {96'b0, tbl[i].e_tap});
    end

    // Same-cycle write/read of scalar 5 while it is reserved.
    @(negedge clk);
    drive(0, 1, 5, 4'h0, 128'h33, 0, 0, 1, 5);
    @(negedge clk);
    drive(0, 1, 5, 4'hF, 128'h12, 5, 5, 0, 0);
    #1;
    chk("byp rd1 same cycle", rd1, BYP ? 128'h12 : 128'h33);
    chk("byp rd2 same cycle", rd2, BYP ? 128'h12 : 128'h33);
    chk("byp busy1 same cycle", {127'b0, busy1}, BYP ? 128'h0 : 128'h1);
    @(negedge clk);
    drive(0, 0, 0, 4'h0, '0, 5, 0, 0, 0);
    #1;
    chk("byp rd1 next cycle", rd1, 128'h12);
    chk("byp busy1 next cycle", {127'b0, busy1}, '0);

    // Reset while vector 12 is busy, with a colliding write and reservation.
    @(negedge clk);
    drive(0, 1, 12, 4'hF, F77, 0, 0, 1, 12);
    @(negedge clk);
    drive(0, 0, 0, 4'h0, '0, 12, 0, 0, 0);
    #1;
    chk("pre-rst rd1[12]", rd1, F77);
    chk("pre-rst busy1[12]", {127'b0, busy1}, 128'h1);
    @(negedge clk);
    drive(1, 1, 12, 4'hF, 128'h99, 0, 0, 1, 12);
    @(negedge clk);
    drive(0, 0, 0, 4'h0, '0, 12, 11, 0, 0);
    #1;
    chk("post-rst rd1[12]", rd1, '0);
    chk("post-rst busy1[12]", {127'b0, busy1}, '0);
    chk("post-rst rd2[11]", rd2, '0);
    chk("post-rst rsv_err", {127'b0, rsv_err}, '0);
    chk("post-rst tap", {96'b0, tap}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
